// File: rtl/ref_sync_pkg.sv
// Shared definitions for the reference-clock qualification and reset
// sequencing logic: state codes, default timing constants, width helper.
package ref_sync_pkg;

  // Sequencer state codes (also driven out on seq_state)
  localparam logic [1:0] WAIT_REF = 2'd0;
  localparam logic [1:0] RELEASE  = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;
  localparam logic [1:0] FAULT    = 2'd3;

  // Default qualification window and sequencing constants
  localparam int DEF_WINDOW      = 1000;
  localparam int DEF_EDGE_MIN    = 9;
  localparam int DEF_EDGE_MAX    = 11;
  localparam int DEF_STAGE_DELAY = 16;
  localparam int DEF_N_STAGES    = 4;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_window_counter.sv
// Counts reference edges over a free-running window of WINDOW cycles and
// judges each completed window against the [EDGE_MIN, EDGE_MAX] range.
module edge_window_counter
  import ref_sync_pkg::*;
#(
  parameter int WINDOW   = DEF_WINDOW,
  parameter int EDGE_MIN = DEF_EDGE_MIN,
  parameter int EDGE_MAX = DEF_EDGE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ref_edge_i,
  output logic win_end_o,
  output logic win_good_o,
  output logic ref_ok_o
);

  localparam int WW = cnt_width(WINDOW);
  // Holds 0..EDGE_MAX+1, so any saturated count is already out of range
  localparam int EW = cnt_width(EDGE_MAX + 2);

  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [EW-1:0] edge_eval;
  logic          ref_ok_q, ref_ok_d;

  // Window position, saturating edge tally (including this cycle's edge) and verdict
  always_comb begin
    win_end_o = (win_cnt_q == WW'(WINDOW - 1));
    edge_eval = edge_cnt_q;
    if (ref_edge_i && (edge_cnt_q != '1)) begin
      edge_eval = edge_cnt_q + 1'b1;
    end
    win_good_o = (edge_eval >= EW'(EDGE_MIN)) && (edge_eval <= EW'(EDGE_MAX));
    win_cnt_d  = win_end_o ? '0 : win_cnt_q + 1'b1;
    edge_cnt_d = win_end_o ? '0 : edge_eval;
    ref_ok_d   = win_end_o ? win_good_o : ref_ok_q;
  end

  // Counter and verdict registers; only rst_n touches the window grid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      ref_ok_q   <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ref_ok_q   <= ref_ok_d;
    end
  end

  assign ref_ok_o = ref_ok_q;

endmodule

// File: rtl/ref_reset_sequencer.sv
// Qualifies the reference clock, then releases the downstream reset stages
// one by one; drops every stage at once on reference loss or sw request.
module ref_reset_sequencer
  import ref_sync_pkg::*;
#(
  parameter int N_STAGES    = DEF_N_STAGES,
  parameter int WINDOW      = DEF_WINDOW,
  parameter int EDGE_MIN    = DEF_EDGE_MIN,
  parameter int EDGE_MAX    = DEF_EDGE_MAX,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ref_edge,
  input  logic                sw_reset_req,
  output logic [N_STAGES-1:0] rst_n_stage,
  output logic                ref_ok,
  output logic                fault,
  output logic [1:0]          seq_state
);

  localparam int SW = cnt_width(N_STAGES);
  localparam int DW = cnt_width(STAGE_DELAY);

  logic                win_end, win_good, bad_window;
  logic                step_done, last_stage;
  logic [1:0]          state_q, state_d;
  logic [1:0]          good_cnt_q, good_cnt_d;
  logic [DW-1:0]       dly_q, dly_d;
  logic [SW-1:0]       stg_q, stg_d;
  logic [N_STAGES-1:0] stage_q, stage_d;
  logic [N_STAGES-1:0] release_bits;
  logic                fault_q, fault_d;

  edge_window_counter #(
    .WINDOW   (WINDOW),
    .EDGE_MIN (EDGE_MIN),
    .EDGE_MAX (EDGE_MAX)
  ) u_edge_window_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .ref_edge_i (ref_edge),
    .win_end_o  (win_end),
    .win_good_o (win_good),
    .ref_ok_o   (ref_ok)
  );

  assign bad_window = win_end && !win_good;
  assign step_done  = (dly_q == DW'(STAGE_DELAY - 1));
  assign last_stage = (stg_q == SW'(N_STAGES - 1));

  // One-hot of the stage whose delay expires this cycle
  generate
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_release
      assign release_bits[gi] = (state_q == RELEASE) && step_done && (stg_q == SW'(gi));
    end
  endgenerate

  // Consecutive good-window tally, saturating at 2
  always_comb begin
    good_cnt_d = good_cnt_q;
    if (win_end) begin
      if (!win_good) begin
        good_cnt_d = 2'd0;
      end else if (good_cnt_q != 2'd2) begin
        good_cnt_d = good_cnt_q + 2'd1;
      end
    end
    if (sw_reset_req || (state_q == FAULT)) begin
      good_cnt_d = 2'd0;
    end
  end

  // Next-state decision; a software request overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_REF: if (win_end && win_good && (good_cnt_q != 2'd0)) state_d = RELEASE;
      RELEASE: begin
        if (bad_window) begin
          state_d = FAULT;
        end else if (step_done && last_stage) begin
          state_d = RUN;
        end
      end
      RUN:      if (bad_window) state_d = FAULT;
      default:  state_d = WAIT_REF;
    endcase
    if (sw_reset_req) begin
      state_d = WAIT_REF;
    end
  end

  // Output and release-counter next values, keyed on the state being entered
  always_comb begin
    stage_d = '0;
    fault_d = fault_q;
    dly_d   = '0;
    stg_d   = '0;
    if ((state_q == RELEASE) && (state_d == RELEASE)) begin
      dly_d = step_done ? '0 : dly_q + 1'b1;
      stg_d = step_done ? stg_q + 1'b1 : stg_q;
    end
    case (state_d)
      RELEASE: stage_d = stage_q | release_bits;
      RUN:     stage_d = '1;
      FAULT:   fault_d = 1'b1;
      default: stage_d = '0;
    endcase
    if (sw_reset_req) begin
      fault_d = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_REF;
    end else begin
      state_q <= state_d;
    end
  end

  // Release counters, tally and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      good_cnt_q <= 2'd0;
      dly_q      <= '0;
      stg_q      <= '0;
      stage_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      good_cnt_q <= good_cnt_d;
      dly_q      <= dly_d;
      stg_q      <= stg_d;
      stage_q    <= stage_d;
      fault_q    <= fault_d;
    end
  end

  assign rst_n_stage = stage_q;
  assign fault       = fault_q;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_ref_reset_sequencer.sv
// Bench for ref_reset_sequencer: a cycle model pushes the expected outputs
// after every clock edge, a monitor pops and compares them on the falling
// edge, and directed checks pin the key latencies.
module tb_ref_reset_sequencer;

  localparam int N    = 4;
  localparam int W    = 100;
  localparam int EMIN = 9;
  localparam int EMAX = 11;
  localparam int SD   = 4;

  localparam int S_WAIT = 0;
  localparam int S_REL  = 1;
  localparam int S_RUN  = 2;
  localparam int S_FLT  = 3;

  typedef struct packed {
    logic [N-1:0] st;
    logic         ok;
    logic         flt;
    logic [1:0]   s;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ref_edge = 1'b0;
  logic         sw_reset_req = 1'b0;
  logic [N-1:0] rst_n_stage;
  logic         ref_ok;
  logic         fault;
  logic [1:0]   seq_state;

  int checks = 0;
  int errors = 0;

  ref_reset_sequencer #(
    .N_STAGES    (N),
    .WINDOW      (W),
    .EDGE_MIN    (EMIN),
    .EDGE_MAX    (EMAX),
    .STAGE_DELAY (SD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ref_edge     (ref_edge),
    .sw_reset_req (sw_reset_req),
    .rst_n_stage  (rst_n_stage),
    .ref_ok       (ref_ok),
    .fault        (fault),
    .seq_state    (seq_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   m_cyc, m_edges, m_good_run, m_state, m_rel_start, m_released;
  bit   m_ref_ok, m_fault;
  obs_t exp_q[$];

  task automatic model_step();
    bit   win_end, in_range;
    int   n;
    obs_t e;
    if (!rst_n) begin
      m_cyc = 0; m_edges = 0; m_good_run = 0; m_state = S_WAIT;
      m_released = 0; m_ref_ok = 0; m_fault = 0;
    end else begin
      win_end  = (m_cyc % W) == (W - 1);
      n        = m_edges + (ref_edge ? 1 : 0);
      in_range = (n >= EMIN) && (n <= EMAX);
      m_edges  = win_end ? 0 : n;
      if (win_end) begin
        m_ref_ok   = in_range;
        m_good_run = in_range ? m_good_run + 1 : 0;
      end
      if (sw_reset_req) begin
        m_state = S_WAIT; m_released = 0; m_fault = 0; m_good_run = 0;
      end else begin
        case (m_state)
          S_WAIT: begin
            if (win_end && m_good_run >= 2) begin
              m_state = S_REL; m_rel_start = m_cyc + 1; m_released = 0;
            end
          end
          S_REL, S_RUN: begin
            if (win_end && !in_range) begin
              m_state = S_FLT; m_released = 0; m_fault = 1; m_good_run = 0;
            end else if (m_state == S_REL) begin
              m_released = (m_cyc + 1 - m_rel_start) / SD;
              if (m_released >= N) begin
                m_released = N; m_state = S_RUN;
              end
            end
          end
          default: begin
            m_state = S_WAIT; m_good_run = 0;
          end
        endcase
      end
      m_cyc++;
    end
    for (int k = 0; k < N; k++) e.st[k] = (k < m_released);
    e.ok  = m_ref_ok;
    e.flt = m_fault;
    e.s   = 2'(m_state);
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    obs_t act, want;
    @(negedge clk);
    act = '{st: rst_n_stage, ok: ref_ok, flt: fault, s: seq_state};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard @%0t: output seen with no expected entry queued", $time);
    end else begin
      want = exp_q.pop_front();
      if (act !== want) begin
        errors++;
        $display("FAIL scoreboard @%0t: got stages=%b ref_ok=%b fault=%b state=%0d, expected stages=%b ref_ok=%b fault=%b state=%0d",
                 $time, act.st, act.ok, act.flt, act.s, want.st, want.ok, want.flt, want.s);
      end
    end
  end

  // ---------------- stimulus ----------------
  int cyc_idx  = 0;
  int cur_k    = 10;
  bit periodic = 1'b1;
  bit pat[W];

  task automatic gen_pattern();
    int placed = 0;
    for (int p = 0; p < W; p++) pat[p] = periodic ? ((p % 10) == 0) : 1'b0;
    if (!periodic) begin
      while (placed < cur_k) begin
        int q = $urandom_range(0, W - 1);
        if (!pat[q]) begin
          pat[q] = 1'b1;
          placed++;
        end
      end
    end
  endtask

  // Drive one cycle; afterwards the DUT shows its outputs for cycle cyc_idx
  task automatic tick(input bit sw);
    if ((cyc_idx % W) == 0) gen_pattern();
    ref_edge     = pat[cyc_idx % W];
    sw_reset_req = sw;
    @(posedge clk);
    #1;
    cyc_idx++;
    ref_edge     = 1'b0;
    sw_reset_req = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; ref_edge = 1'b0; sw_reset_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cyc_idx = 0;
  endtask

  task automatic check_int(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic wait_state(input int s, input int limit, input string name, output int n);
    n = 0;
    while ((int'(seq_state) != s) && (n < limit)) begin
      tick(1'b0);
      n++;
    end
    check_int(name, int'(seq_state), s);
  endtask

  initial begin
    int t_ok, t_rel, t_run, n;
    int t_stage[N];
    bit left_wait, saw_ok;

    do_reset(2);
    check_int("reset stages", int'(rst_n_stage), 0);
    check_int("reset state", int'(seq_state), S_WAIT);

    // Phase 1: nominal startup, one edge every 10 cycles
    t_ok = -1; t_rel = -1; t_run = -1;
    for (int k = 0; k < N; k++) t_stage[k] = -1;
    for (int i = 0; i < 230; i++) begin
      tick(1'b0);
      if (ref_ok && t_ok < 0) t_ok = cyc_idx;
      if (seq_state == 2'(S_REL) && t_rel < 0) t_rel = cyc_idx;
      if (seq_state == 2'(S_RUN) && t_run < 0) t_run = cyc_idx;
      for (int k = 0; k < N; k++) if (rst_n_stage[k] && t_stage[k] < 0) t_stage[k] = cyc_idx;
    end
    check_int("p1 ref_ok rise cycle", t_ok, 100);
    check_int("p1 release cycle", t_rel, 200);
    for (int k = 0; k < N; k++) check_int($sformatf("p1 stage%0d rise cycle", k), t_stage[k], 204 + SD * k);
    check_int("p1 run cycle", t_run, 216);
    $display("phase 1 nominal startup done at cycle %0d", cyc_idx);

    // Phase 2: reference lost for one full window while running
    while ((cyc_idx % W) != 0) tick(1'b0);
    periodic = 1'b0;
    cur_k    = 0;
    repeat (W) tick(1'b0);
    check_int("p2 fault flag", int'(fault), 1);
    check_int("p2 fault state", int'(seq_state), S_FLT);
    check_int("p2 stages dropped", int'(rst_n_stage), 0);
    check_int("p2 ref_ok dropped", int'(ref_ok), 0);
    cur_k = 12;
    tick(1'b0);
    check_int("p2 back to wait", int'(seq_state), S_WAIT);
    $display("phase 2 reference loss done at cycle %0d", cyc_idx);

    // Phase 3: 12 edges per window never qualifies, 10 does
    left_wait = 1'b0; saw_ok = 1'b0;
    repeat (3 * W) begin
      tick(1'b0);
      if (seq_state != 2'(S_WAIT)) left_wait = 1'b1;
      if (ref_ok) saw_ok = 1'b1;
    end
    while ((cyc_idx % W) != 0) tick(1'b0);
    check_int("p3 stayed in wait", int'(left_wait), 0);
    check_int("p3 ref_ok stayed low", int'(saw_ok), 0);
    cur_k = 10;
    wait_state(S_REL, 3 * W, "p3 reached release", n);
    check_int("p3 release latency", n, 2 * W);
    $display("phase 3 out-of-range count done at cycle %0d", cyc_idx);

    // Phase 4: software reset once stage 1 is released
    n = 0;
    while (!rst_n_stage[1] && n < 50) begin
      tick(1'b0);
      n++;
    end
    check_int("p4 stage1 released", int'(rst_n_stage[1]), 1);
    tick(1'b1);
    check_int("p4 stages cleared", int'(rst_n_stage), 0);
    check_int("p4 fault clear", int'(fault), 0);
    check_int("p4 wait state", int'(seq_state), S_WAIT);
    begin
      int want_lat;
      want_lat = (W - (cyc_idx % W)) + W;
      wait_state(S_REL, 4 * W, "p4 requalified", n);
      check_int("p4 requalify latency", n, want_lat);
    end
    $display("phase 4 software reset done at cycle %0d", cyc_idx);

    // Phase 5: sw request on the cycle a bad window would fault
    wait_state(S_RUN, 4 * W, "p5 reached run", n);
    while ((cyc_idx % W) != 0) tick(1'b0);
    cur_k = 0;
    repeat (W - 1) tick(1'b0);
    tick(1'b1);
    check_int("p5 fault suppressed", int'(fault), 0);
    check_int("p5 wait state", int'(seq_state), S_WAIT);
    check_int("p5 ref_ok updated", int'(ref_ok), 0);
    $display("phase 5 priority done at cycle %0d", cyc_idx);

    // Phase 6: one-cycle rst_n pulse while running
    cur_k = 10;
    wait_state(S_RUN, 4 * W, "p6 reached run", n);
    do_reset(1);
    check_int("p6 stages reset", int'(rst_n_stage), 0);
    check_int("p6 ref_ok reset", int'(ref_ok), 0);
    check_int("p6 fault reset", int'(fault), 0);
    check_int("p6 state reset", int'(seq_state), S_WAIT);
    $display("phase 6 reset mid-operation done at cycle %0d", cyc_idx);

    // Phase 7: randomized soak around the count boundaries
    for (int i = 0; i < 4000; i++) begin
      if ((cyc_idx % W) == 0) begin
        cur_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(9, 11));
      end
      tick($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 2999) == 0) do_reset(1);
    end
    $display("phase 7 random soak done at cycle %0d", cyc_idx);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
